// File: rtl/io_bus_copier_if.sv
// io_bus_copier_if: IO-bus strobes, address and data between the copier (initiator) and peripherals.
interface io_bus_copier_if;
  logic        wReadEnable;
  logic        wWriteEnable;
  logic [3:0]  wByteEnable;
  logic [31:0] wAddress;
  logic [31:0] wWriteData;
  logic [31:0] wReadData;
  modport master (output wReadEnable, wWriteEnable, wByteEnable, wAddress, wWriteData, input wReadData);
  modport slave  (input wReadEnable, wWriteEnable, wByteEnable, wAddress, wWriteData, output wReadData);
endinterface

// File: rtl/io_bus_copier.sv
// io_bus_copier: word copier issuing one IO-bus read then one write per word, with abort and fixed/incrementing addresses.
module io_bus_copier #(
  parameter int LEN_W       = 16,
  parameter int WORD_STRIDE = 4
) (
  input  logic             iCLK,
  input  logic             iRST_n,
  input  logic             iStart,
  input  logic             iAbort,
  input  logic [31:0]      iSrcAddr,
  input  logic [31:0]      iDstAddr,
  input  logic [LEN_W-1:0] iLen,
  input  logic             iSrcInc,
  input  logic             iDstInc,
  output logic             oBusy,
  output logic             oDone,
  output logic [LEN_W-1:0] oCount,
  io_bus_copier_if.master  bus
);
  typedef enum logic [1:0] {IDLE, READ, WRITE, DONE} state_t;
  localparam logic [31:0] stride = 32'(WORD_STRIDE);
  state_t state_q, state_d;
  logic [31:0] src_q, src_d, dst_q, dst_d, data_q, data_d;
  logic [LEN_W-1:0] len_q, len_d, cnt_q, cnt_d, cnt_inc;
  logic src_inc_q, src_inc_d, dst_inc_q, dst_inc_d;
  assign cnt_inc = cnt_q + LEN_W'(1);
  always_ff @(posedge iCLK or negedge iRST_n)
    if (!iRST_n) state_q <= IDLE;
    else         state_q <= state_d;
  always_comb begin
    state_d = IDLE;
    unique case (state_q)
      IDLE:    state_d = !iStart ? IDLE : (iLen == '0) ? DONE : READ;
      READ:    state_d = iAbort ? DONE : WRITE;
      WRITE:   state_d = (iAbort || cnt_inc == len_q) ? DONE : READ;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge iCLK or negedge iRST_n)
    if (!iRST_n) begin
      src_q     <= '0;
      dst_q     <= '0;
      data_q    <= '0;
      len_q     <= '0;
      cnt_q     <= '0;
      src_inc_q <= 1'b0;
      dst_inc_q <= 1'b0;
    end else begin
      src_q     <= src_d;
      dst_q     <= dst_d;
      data_q    <= data_d;
      len_q     <= len_d;
      cnt_q     <= cnt_d;
      src_inc_q <= src_inc_d;
      dst_inc_q <= dst_inc_d;
    end
  always_comb begin
    src_d     = src_q;
    dst_d     = dst_q;
    data_d    = data_q;
    len_d     = len_q;
    cnt_d     = cnt_q;
    src_inc_d = src_inc_q;
    dst_inc_d = dst_inc_q;
    if (state_q == IDLE && iStart) begin
      src_d     = iSrcAddr;
      dst_d     = iDstAddr;
      len_d     = iLen;
      src_inc_d = iSrcInc;
      dst_inc_d = iDstInc;
      cnt_d     = '0;
    end
    if (state_q == READ) data_d = bus.wReadData;
    // a write always completes, so abort in WRITE still counts and advances
    if (state_q == WRITE) begin
      cnt_d = cnt_inc;
      src_d = src_q + (src_inc_q ? stride : 32'd0);
      dst_d = dst_q + (dst_inc_q ? stride : 32'd0);
    end
  end
  always_comb begin
    bus.wReadEnable  = state_q == READ;
    bus.wWriteEnable = state_q == WRITE;
    bus.wByteEnable  = (state_q == READ || state_q == WRITE) ? 4'b1111 : 4'b0000;
    bus.wAddress     = (state_q == READ) ? src_q : (state_q == WRITE) ? dst_q : 32'd0;
    bus.wWriteData   = (state_q == WRITE) ? data_q : 32'd0;
    oBusy            = state_q == READ || state_q == WRITE;
    oDone            = state_q == DONE;
    oCount           = cnt_q;
  end
endmodule
